// File: rtl/service_queue_mc_pkg.sv
// service_queue_mc_pkg: shared constants and helpers for the service queue
package service_queue_mc_pkg;
   localparam int MAX_NCH = 8;
   // Pointer increment that wraps by compare so DEPTH need not be a power of two
   function automatic int wrap_inc(input int p, input int depth);
      return (p == depth - 1) ? 0 : p + 1;
   endfunction
endpackage

// File: rtl/service_channel.sv
// service_channel: one countdown service channel
// Ports: clk, rst_n (sync, active-low); ld loads ld_num/ld_tim and sets busy;
// tick decrements rem while busy; done pulses for one cycle when rem reaches 0;
// num holds the last served number until the next load.
module service_channel #(
   parameter int DT_SZ = 4
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             ld,
   input  logic             tick,
   input  logic [DT_SZ-1:0] ld_num,
   input  logic [DT_SZ-1:0] ld_tim,
   output logic             busy,
   output logic             done,
   output logic [DT_SZ-1:0] num,
   output logic [DT_SZ-1:0] rem
);
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         busy <= 1'b0;
         done <= 1'b0;
         num  <= '0;
         rem  <= '0;
      end else begin
         done <= 1'b0;
         if (ld) begin
            busy <= 1'b1;
            num  <= ld_num;
            rem  <= ld_tim;
         end else if (tick && busy) begin
            rem <= rem - DT_SZ'(1);
            if (rem == DT_SZ'(1)) begin
               busy <= 1'b0;
               done <= 1'b1;
            end
         end
      end
   end
endmodule

// File: rtl/service_queue_defs.vh
// service_queue_defs: entry layout and parameter legality checks, included inside modules
localparam int ENTRY_W = 2 * DT_SZ;
localparam int NUM_HI = ENTRY_W - 1;
localparam int NUM_LO = DT_SZ;
localparam int TIM_HI = DT_SZ - 1;
localparam int TIM_LO = 0;
if ((1 << PTR_W) <= DEPTH) begin : g_bad_ptr_w
   $error("PTR_W too narrow: 2^PTR_W must exceed DEPTH");
end
if (NCH < 1 || NCH > MAX_NCH) begin : g_bad_nch
   $error("NCH must be in 1..8");
end

// File: rtl/service_queue_mc.sv
// service_queue_mc: circular FIFO of {num, time} entries dispatched to NCH countdown channels
// Ports: clk, rst_n (sync, active-low); we/dn/dt enqueue (dt=0 illegal); tick is the time base;
// full/empty/count give queue state; drop pulses on a rejected write;
// ch_busy/ch_num/ch_rem/done are per-channel (channel c at [c*DT_SZ +: DT_SZ]);
// qdbg is the FIFO in logical order, slot 0 = head, slots >= count read 0.
module service_queue_mc
   import service_queue_mc_pkg::*;
#(
   parameter int DT_SZ = 4,
   parameter int DEPTH = 3,
   parameter int PTR_W = 2,
   parameter int NCH   = 2
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic                     we,
   input  logic [DT_SZ-1:0]         dn,
   input  logic [DT_SZ-1:0]         dt,
   input  logic                     tick,
   output logic                     full,
   output logic                     empty,
   output logic [PTR_W-1:0]         count,
   output logic                     drop,
   output logic [NCH-1:0]           ch_busy,
   output logic [NCH*DT_SZ-1:0]     ch_num,
   output logic [NCH*DT_SZ-1:0]     ch_rem,
   output logic [NCH-1:0]           done,
   output logic [DEPTH*2*DT_SZ-1:0] qdbg
);
   `include "service_queue_defs.vh"
   localparam logic [PTR_W-1:0] DEPTH_P = PTR_W'(DEPTH);
   logic [ENTRY_W-1:0] mem [DEPTH];
   logic [ENTRY_W-1:0] hd;
   logic [PTR_W-1:0]   head, tail, cnt, ix;
   logic [3:0]         sel;
   logic               idle, disp, acc;
   assign count = cnt;
   assign full  = cnt == DEPTH_P;
   assign empty = cnt == '0;
   assign hd    = mem[head];
   // Dispatch works on registered state only, so a fresh write never bypasses to a channel
   assign disp  = !empty && idle;
   assign acc   = we && dt != '0 && (!full || disp);
   always_comb begin
      sel  = '0;
      idle = 1'b0;
      for (int c = NCH - 1; c >= 0; c--) begin
         if (!ch_busy[c]) begin
            sel  = 4'(c);
            idle = 1'b1;
         end
      end
   end
   always_comb begin
      qdbg = '0;
      ix   = '0;
      for (int i = 0; i < DEPTH; i++) begin
         ix = PTR_W'((int'(head) + i) % DEPTH);
         if (PTR_W'(i) < cnt) qdbg[i*ENTRY_W +: ENTRY_W] = mem[ix];
      end
   end
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         head <= '0;
         tail <= '0;
         cnt  <= '0;
         drop <= 1'b0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         drop <= we && !acc;
         if (acc) begin
            mem[tail] <= {dn, dt};
            tail      <= PTR_W'(wrap_inc(int'(tail), DEPTH));
         end
         if (disp) head <= PTR_W'(wrap_inc(int'(head), DEPTH));
         cnt <= cnt + PTR_W'(acc) - PTR_W'(disp);
      end
   end
   for (genvar c = 0; c < NCH; c++) begin : g_ch
      service_channel #(.DT_SZ(DT_SZ)) u_ch (
         .clk    (clk),
         .rst_n  (rst_n),
         .ld     (disp && sel == 4'(c)),
         .tick   (tick),
         .ld_num (hd[NUM_HI:NUM_LO]),
         .ld_tim (hd[TIM_HI:TIM_LO]),
         .busy   (ch_busy[c]),
         .done   (done[c]),
         .num    (ch_num[c*DT_SZ +: DT_SZ]),
         .rem    (ch_rem[c*DT_SZ +: DT_SZ])
      );
   end
endmodule

// File: tb/tb_service_queue_mc.sv
// tb_service_queue_mc: directed table, corner sequences and random run against a queue-based model
module tb_service_queue_mc;
   localparam int DT = 4, DP = 3, PW = 2, NC = 2;
   logic clk = 1'b0, rst_n = 1'b0, we = 1'b0, tick = 1'b0;
   logic [DT-1:0] dn = '0, dt = '0;
   logic full, empty, drop;
   logic [PW-1:0] count;
   logic [NC-1:0] ch_busy, done;
   logic [NC*DT-1:0] ch_num, ch_rem;
   logic [DP*2*DT-1:0] qdbg;
   int n_pass = 0, n_tot = 0;
   service_queue_mc #(.DT_SZ(DT), .DEPTH(DP), .PTR_W(PW), .NCH(NC)) dut (
      .clk(clk), .rst_n(rst_n), .we(we), .dn(dn), .dt(dt), .tick(tick),
      .full(full), .empty(empty), .count(count), .drop(drop),
      .ch_busy(ch_busy), .ch_num(ch_num), .ch_rem(ch_rem), .done(done), .qdbg(qdbg)
   );
   always #5 clk = ~clk;
   logic [7:0] mq[$];
   bit m_busy[NC], m_done[NC], m_drop;
   int m_num[NC], m_rem[NC];
   typedef struct {
      logic r, w; logic [3:0] n, t; logic k;
      logic [1:0] cnt, busy, dn_; logic drp; logic [7:0] num, rem, q0;
   } vec_t;
   vec_t tbl[$];
   task automatic chk(input string nm, input logic [31:0] a, input logic [31:0] e);
      n_tot++;
      if (a === e) n_pass++;
      else $display("FAIL %s: got %0h expected %0h at %0t", nm, a, e, $time);
   endtask
   task automatic model_step(input logic r, w, input logic [3:0] n, t, input logic k);
      int idl;
      bit dsp, ac;
      if (!r) begin
         mq.delete();
         m_drop = 0;
         for (int c = 0; c < NC; c++) begin
            m_busy[c] = 0; m_done[c] = 0; m_num[c] = 0; m_rem[c] = 0;
         end
         return;
      end
      idl = -1;
      for (int c = NC - 1; c >= 0; c--) if (!m_busy[c]) idl = c;
      dsp = mq.size() > 0 && idl >= 0;
      ac = w && t != 0 && (mq.size() < DP || dsp);
      m_drop = w && !ac;
      for (int c = 0; c < NC; c++) begin
         m_done[c] = 0;
         if (dsp && c == idl) begin
            m_busy[c] = 1; m_num[c] = int'(mq[0][7:4]); m_rem[c] = int'(mq[0][3:0]);
         end else if (k && m_busy[c]) begin
            m_rem[c]--;
            if (m_rem[c] == 0) begin m_busy[c] = 0; m_done[c] = 1; end
         end
      end
      if (dsp) void'(mq.pop_front());
      if (ac) mq.push_back({n, t});
   endtask
   task automatic model_cmp();
      logic [1:0] eb, ed;
      logic [7:0] en, er;
      logic [23:0] eq;
      eq = '0;
      for (int c = 0; c < NC; c++) begin
         eb[c] = m_busy[c]; ed[c] = m_done[c];
         en[c*4 +: 4] = 4'(m_num[c]); er[c*4 +: 4] = 4'(m_rem[c]);
      end
      for (int i = 0; i < mq.size(); i++) eq[i*8 +: 8] = mq[i];
      chk("m_count", 32'(count), 32'(mq.size()));
      chk("m_full", 32'(full), 32'(mq.size() == DP));
      chk("m_empty", 32'(empty), 32'(mq.size() == 0));
      chk("m_drop", 32'(drop), 32'(m_drop));
      chk("m_busy", 32'(ch_busy), 32'(eb));
      chk("m_done", 32'(done), 32'(ed));
      chk("m_num", 32'(ch_num), 32'(en));
      chk("m_rem", 32'(ch_rem), 32'(er));
      chk("m_qdbg", 32'(qdbg), 32'(eq));
   endtask
   task automatic cyc(input logic r, w, input logic [3:0] n, t, input logic k);
      rst_n = r; we = w; dn = n; dt = t; tick = k;
      @(posedge clk);
      #1;
      model_step(r, w, n, t, k);
      model_cmp();
   endtask
   task automatic add(input logic r, w, input logic [3:0] n, t, input logic k,
                      input logic [1:0] c, b, d, input logic dr, input logic [7:0] nm, rm, q);
      tbl.push_back('{r, w, n, t, k, c, b, d, dr, nm, rm, q});
   endtask
   initial begin
      add(0,1,4'h9,4'h3,0, 0,2'b00,2'b00,0, 8'h00,8'h00,8'h00);
      add(0,1,4'h9,4'h3,0, 0,2'b00,2'b00,0, 8'h00,8'h00,8'h00);
      add(1,1,4'h1,4'h3,0, 1,2'b00,2'b00,0, 8'h00,8'h00,8'h13);
      add(1,1,4'h2,4'h2,0, 1,2'b01,2'b00,0, 8'h01,8'h03,8'h22);
      add(1,1,4'h3,4'h1,0, 1,2'b11,2'b00,0, 8'h21,8'h23,8'h31);
      add(1,1,4'h4,4'h4,0, 2,2'b11,2'b00,0, 8'h21,8'h23,8'h31);
      add(1,1,4'h5,4'h5,0, 3,2'b11,2'b00,0, 8'h21,8'h23,8'h31);
      add(1,1,4'h6,4'h6,0, 3,2'b11,2'b00,1, 8'h21,8'h23,8'h31);
      add(1,0,4'h0,4'h0,1, 3,2'b11,2'b00,0, 8'h21,8'h12,8'h31);
      add(1,0,4'h0,4'h0,1, 3,2'b01,2'b10,0, 8'h21,8'h01,8'h31);
      add(1,0,4'h0,4'h0,0, 2,2'b11,2'b00,0, 8'h31,8'h11,8'h44);
      add(1,0,4'h0,4'h0,1, 2,2'b00,2'b11,0, 8'h31,8'h00,8'h44);
      add(1,0,4'h0,4'h0,0, 1,2'b01,2'b00,0, 8'h34,8'h04,8'h55);
      add(1,1,4'h6,4'h3,0, 1,2'b11,2'b00,0, 8'h54,8'h54,8'h63);
      add(1,1,4'hA,4'h1,0, 2,2'b11,2'b00,0, 8'h54,8'h54,8'h63);
      add(1,1,4'hB,4'h2,0, 3,2'b11,2'b00,0, 8'h54,8'h54,8'h63);
      add(1,0,4'h0,4'h0,1, 3,2'b11,2'b00,0, 8'h54,8'h43,8'h63);
      add(1,0,4'h0,4'h0,1, 3,2'b11,2'b00,0, 8'h54,8'h32,8'h63);
      add(1,0,4'h0,4'h0,1, 3,2'b11,2'b00,0, 8'h54,8'h21,8'h63);
      add(1,0,4'h0,4'h0,1, 3,2'b10,2'b01,0, 8'h54,8'h10,8'h63);
      add(1,1,4'h7,4'h2,0, 3,2'b11,2'b00,0, 8'h56,8'h13,8'hA1);
      for (int i = 0; i < tbl.size(); i++) begin
         cyc(tbl[i].r, tbl[i].w, tbl[i].n, tbl[i].t, tbl[i].k);
         chk($sformatf("t%0d_count", i), 32'(count), 32'(tbl[i].cnt));
         chk($sformatf("t%0d_busy", i), 32'(ch_busy), 32'(tbl[i].busy));
         chk($sformatf("t%0d_done", i), 32'(done), 32'(tbl[i].dn_));
         chk($sformatf("t%0d_drop", i), 32'(drop), 32'(tbl[i].drp));
         chk($sformatf("t%0d_num", i), 32'(ch_num), 32'(tbl[i].num));
         chk($sformatf("t%0d_rem", i), 32'(ch_rem), 32'(tbl[i].rem));
         chk($sformatf("t%0d_q0", i), 32'(qdbg[7:0]), 32'(tbl[i].q0));
      end
      cyc(0,0,0,0,0);
      cyc(1,1,4'h8,4'h0,0);
      chk("illegal_drop", 32'(drop), 32'd1);
      chk("illegal_empty", 32'(empty), 32'd1);
      cyc(1,1,4'h9,4'h1,0);
      chk("nobypass_busy", 32'(ch_busy), 32'd0);
      chk("nobypass_count", 32'(count), 32'd1);
      cyc(1,0,0,0,0);
      chk("load_busy", 32'(ch_busy), 32'd1);
      chk("load_num", 32'(ch_num[3:0]), 32'h9);
      cyc(1,0,0,0,1);
      chk("finish_done", 32'(done), 32'd1);
      cyc(1,1,4'h3,4'h2,0);
      cyc(1,0,0,0,0);
      chk("mid_rem", 32'(ch_rem[3:0]), 32'd2);
      cyc(0,0,0,0,1);
      chk("rst_busy", 32'(ch_busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_count", 32'(count), 32'd0);
      for (int i = 0; i < 3; i++) begin
         cyc(1,0,0,0,1);
         chk("post_rst_done", 32'(done), 32'd0);
      end
      for (int i = 0; i < 3000; i++) begin
         logic r, w, k;
         logic [3:0] n, t;
         r = $urandom_range(0, 63) != 0;
         w = $urandom_range(0, 1) == 1;
         n = 4'($urandom);
         t = ($urandom_range(0, 9) == 0) ? 4'd0 : 4'($urandom_range(1, 6));
         k = $urandom_range(0, 2) == 0;
         cyc(r, w, n, t, k);
      end
      $display("%0d/%0d checks passed", n_pass, n_tot);
      $finish;
   end
endmodule
